// File: rtl/dma_fifo_drain.sv
// dma_fifo_drain
//   Read-side engine for the DMA data FIFO. It pops a programmed number of
//   beats and presents them as a valid/ready stream. Pops are tracked while
//   their data is in flight (the FIFO answers OUTPUT_DELAY cycles after a
//   pop). A small skid buffer absorbs every in-flight beat, so backpressure
//   never loses data and throughput stays at one beat per cycle.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start_i
//   RUN   | popping the FIFO; beats stream out as they return
//   DRAIN | all pops issued; emptying in-flight data and skid buffer
//   DONE  | one-cycle completion pulse on done_o
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   clear_i            synchronous abort/flush (wins over start_i)
//   start_i, len_i     start a transfer of len_i beats (sampled in IDLE)
//   busy_o, done_o     RUN/DRAIN indicator, completion pulse
//   fifo_read_o        FIFO pop request
//   fifo_empty_i       FIFO empty flag
//   fifo_data_i        FIFO read data, OUTPUT_DELAY cycles after a pop
//   m_valid_o, m_ready_i, m_data_o, m_last_o   output stream
module dma_fifo_drain #(
    parameter int WIDTH        = 128,
    parameter int OUTPUT_DELAY = 1,
    parameter int LEN_W        = 16,
    parameter int SKID_DEPTH   = OUTPUT_DELAY + 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             fifo_read_o,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_last_o
);

    localparam int CNT_W = $clog2(SKID_DEPTH + 1);
    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [LEN_W-1:0]        rem_pop;
    logic [LEN_W-1:0]        rem_out;
    logic [OUTPUT_DELAY-1:0] inflight_sr;
    logic [CNT_W-1:0]        inflight_cnt;
    logic [CNT_W-1:0]        skid_cnt;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [WIDTH-1:0]        skid_mem [SKID_DEPTH];
    logic [CNT_W:0]          occupancy;
    logic                    pop;
    logic                    push;
    logic                    hs;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        // depth need not be a power of two, so wrap explicitly
        if (p == PTR_W'(SKID_DEPTH - 1))
            return '0;
        return p + PTR_W'(1);
    endfunction

    // Slots already promised (in flight) plus slots holding data. Only
    // registered counts are used, so a freed slot is credited next cycle.
    assign occupancy   = {1'b0, inflight_cnt} + {1'b0, skid_cnt};
    assign pop         = (state == S_RUN) & ~fifo_empty_i & (rem_pop != '0)
                         & (occupancy < (CNT_W+1)'(SKID_DEPTH));
    assign push        = inflight_sr[OUTPUT_DELAY-1];
    assign fifo_read_o = pop;

    assign m_valid_o = (skid_cnt != '0);
    assign hs        = m_valid_o & m_ready_i;
    assign m_data_o  = skid_mem[rd_ptr];
    assign m_last_o  = m_valid_o & (rem_out == LEN_W'(1));

    assign busy_o = (state == S_RUN) || (state == S_DRAIN);
    assign done_o = (state == S_DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_i) state_nxt = (len_i != '0) ? S_RUN : S_DONE;
            S_RUN:   if (pop && rem_pop == LEN_W'(1)) state_nxt = S_DRAIN;
            S_DRAIN: if (hs && m_last_o) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (clear_i)
            state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rem_pop      <= '0;
            rem_out      <= '0;
            inflight_sr  <= '0;
            inflight_cnt <= '0;
            skid_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            for (int i = 0; i < SKID_DEPTH; i++)
                skid_mem[i] <= '0;
        end else if (clear_i) begin
            // zeroing the shift register discards data still in flight
            rem_pop      <= '0;
            rem_out      <= '0;
            inflight_sr  <= '0;
            inflight_cnt <= '0;
            skid_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            for (int i = 0; i < SKID_DEPTH; i++)
                skid_mem[i] <= '0;
        end else begin
            if (state == S_IDLE && start_i) begin
                rem_pop <= len_i;
                rem_out <= len_i;
            end else begin
                if (pop)
                    rem_pop <= rem_pop - LEN_W'(1);
                if (hs)
                    rem_out <= rem_out - LEN_W'(1);
            end

            for (int i = OUTPUT_DELAY - 1; i > 0; i--)
                inflight_sr[i] <= inflight_sr[i-1];
            inflight_sr[0] <= pop;
            inflight_cnt   <= inflight_cnt + CNT_W'(pop) - CNT_W'(push);

            if (push) begin
                skid_mem[wr_ptr] <= fifo_data_i;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (hs)
                rd_ptr <= ptr_inc(rd_ptr);
            skid_cnt <= skid_cnt + CNT_W'(push) - CNT_W'(hs);
        end
    end

endmodule

// File: tb/tb_dma_fifo_drain.sv
module tb_dma_fifo_drain;

    localparam int WIDTH = 128;
    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             clear_i = 1'b0;
    logic             start_i = 1'b0;
    logic [LEN_W-1:0] len_i = '0;
    logic             busy_o, done_o, fifo_read_o, fifo_empty_i;
    logic [WIDTH-1:0] fifo_data_i = '0;
    logic             m_valid_o, m_last_o;
    logic             m_ready_i = 1'b0;
    logic [WIDTH-1:0] m_data_o;

    always #5 clk = ~clk;

    dma_fifo_drain #(.WIDTH(WIDTH), .OUTPUT_DELAY(1), .LEN_W(LEN_W)) dut (
        .clk(clk), .rstn(rstn), .clear_i(clear_i), .start_i(start_i),
        .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
        .fifo_read_o(fifo_read_o), .fifo_empty_i(fifo_empty_i),
        .fifo_data_i(fifo_data_i), .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o)
    );

    typedef struct packed {
        logic             last;
        logic [WIDTH-1:0] data;
    } beat_t;

    logic [WIDTH-1:0] fifo_q[$];
    beat_t            exp_q[$];
    int               errors = 0;
    int               checks = 0;
    int               loads = 0;
    int               pops = 0;

    // FIFO model: one cycle read latency; empty derived from load/pop counts
    assign fifo_empty_i = (loads == pops);

    always @(posedge clk) begin
        if (fifo_read_o) begin
            checks++;
            if (fifo_q.size() == 0) begin
                errors++;
                $display("FAIL fifo_underflow: pop issued with model FIFO empty");
            end else begin
                fifo_data_i <= fifo_q.pop_front();
            end
            pops <= pops + 1;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin : mon
        beat_t e;
        if (rstn && m_valid_o && m_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got data=%0h last=%0b, none expected",
                         m_data_o, m_last_o);
            end else begin
                e = exp_q.pop_front();
                if (m_data_o !== e.data || m_last_o !== e.last) begin
                    errors++;
                    $display("FAIL beat: got data=%0h last=%0b required data=%0h last=%0b",
                             m_data_o, m_last_o, e.data, e.last);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string n, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0b required %0b", n, a, e);
        end
    endtask

    task automatic chkw(input string n, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", n, a, e);
        end
    endtask

    task automatic chki(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", n, a, e);
        end
    endtask

    task automatic fifo_load(input logic [WIDTH-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(base + WIDTH'(i));
            loads++;
        end
    endtask

    task automatic fifo_flush();
        fifo_q.delete();
        loads = pops;
    endtask

    task automatic exp_push(input logic [WIDTH-1:0] base, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.last = (i == n - 1);
            b.data = base + WIDTH'(i);
            exp_q.push_back(b);
        end
    endtask

    task automatic run_done(input int n, output int dn);
        dn = 0;
        repeat (n) begin
            @(negedge clk);
            if (done_o) dn++;
        end
    endtask

    task automatic chk_zero(input string n);
        chk1({n, "_busy"}, busy_o, 1'b0);
        chk1({n, "_done"}, done_o, 1'b0);
        chk1({n, "_read"}, fifo_read_o, 1'b0);
        chk1({n, "_valid"}, m_valid_o, 1'b0);
        chk1({n, "_last"}, m_last_o, 1'b0);
        chkw({n, "_data"}, m_data_o, '0);
    endtask

    logic [8:0] rd_m, vld_m, dn_m, bsy_m, lst_m;
    int         dn;
    int         p0;

    initial begin
        #12;
        chk_zero("reset");
        @(posedge clk); #1;
        rstn = 1'b1;
        step();

        // 1: len 4, ready high, start in cycle 0
        rd_m  = 9'h01E;
        vld_m = 9'h078;
        lst_m = 9'h040;
        dn_m  = 9'h080;
        bsy_m = 9'h07E;
        fifo_load('h0, 8);
        exp_push('h0, 4);
        m_ready_i = 1'b1;
        start_i = 1'b1;
        len_i = 16'd4;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk1($sformatf("t1_read_c%0d", c), fifo_read_o, rd_m[c]);
            chk1($sformatf("t1_valid_c%0d", c), m_valid_o, vld_m[c]);
            chk1($sformatf("t1_last_c%0d", c), m_last_o, lst_m[c]);
            chk1($sformatf("t1_done_c%0d", c), done_o, dn_m[c]);
            chk1($sformatf("t1_busy_c%0d", c), busy_o, bsy_m[c]);
            step();
            start_i = 1'b0;
        end
        chki("t1_fifo_left", fifo_q.size(), 4);
        chki("t1_sb_empty", exp_q.size(), 0);
        fifo_flush();

        // 2: backpressure, len 10
        m_ready_i = 1'b0;
        fifo_load('h100, 10);
        exp_push('h100, 10);
        p0 = pops;
        start_i = 1'b1;
        len_i = 16'd10;
        step();
        start_i = 1'b0;
        repeat (9) step();
        @(negedge clk);
        chki("t2_pops_held", pops - p0, 3);
        chk1("t2_read_low", fifo_read_o, 1'b0);
        chk1("t2_valid", m_valid_o, 1'b1);
        chkw("t2_head", m_data_o, 'h100);
        repeat (6) step();
        @(negedge clk);
        chkw("t2_head_stable", m_data_o, 'h100);
        chki("t2_pops_still", pops - p0, 3);
        step();
        m_ready_i = 1'b1;
        run_done(25, dn);
        chki("t2_done_pulses", dn, 1);
        chki("t2_sb_empty", exp_q.size(), 0);
        chki("t2_fifo_left", fifo_q.size(), 0);

        // 3: empty stall
        step();
        start_i = 1'b1;
        len_i = 16'd3;
        step();
        start_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk1($sformatf("t3_read_low_%0d", c), fifo_read_o, 1'b0);
            chk1($sformatf("t3_busy_%0d", c), busy_o, 1'b1);
            step();
        end
        fifo_load('h200, 3);
        exp_push('h200, 3);
        run_done(15, dn);
        chki("t3_done_pulses", dn, 1);
        chk1("t3_busy_after", busy_o, 1'b0);
        chki("t3_sb_empty", exp_q.size(), 0);

        // 4: zero length; start in cycle 1, done in cycle 2
        step();
        fifo_load('h2F0, 1);
        p0 = pops;
        @(negedge clk);
        chk1("t4_done_c0", done_o, 1'b0);
        step();
        start_i = 1'b1;
        len_i = 16'd0;
        @(negedge clk);
        chk1("t4_done_c1", done_o, 1'b0);
        chk1("t4_valid_c1", m_valid_o, 1'b0);
        step();
        start_i = 1'b0;
        @(negedge clk);
        chk1("t4_done_c2", done_o, 1'b1);
        chk1("t4_busy_c2", busy_o, 1'b0);
        chk1("t4_read_c2", fifo_read_o, 1'b0);
        step();
        @(negedge clk);
        chk1("t4_done_c3", done_o, 1'b0);
        chk1("t4_busy_c3", busy_o, 1'b0);
        chki("t4_no_pops", pops - p0, 0);
        step();
        fifo_flush();

        // 5: abort after two accepted beats
        fifo_load('h300, 6);
        exp_push('h300, 2);
        exp_q[1].last = 1'b0;
        m_ready_i = 1'b1;
        start_i = 1'b1;
        len_i = 16'd6;
        step();
        start_i = 1'b0;
        repeat (4) step();
        m_ready_i = 1'b0;
        clear_i = 1'b1;
        @(negedge clk);
        chk1("t5_pop_at_abort", fifo_read_o, 1'b1);
        chki("t5_two_accepted", exp_q.size(), 0);
        step();
        clear_i = 1'b0;
        @(negedge clk);
        chk1("t5_busy", busy_o, 1'b0);
        chk1("t5_valid", m_valid_o, 1'b0);
        chk1("t5_done", done_o, 1'b0);
        run_done(4, dn);
        chki("t5_no_done", dn, 0);
        chk1("t5_valid_later", m_valid_o, 1'b0);
        step();
        fifo_flush();
        fifo_load('h400, 2);
        exp_push('h400, 2);
        m_ready_i = 1'b1;
        start_i = 1'b1;
        len_i = 16'd2;
        step();
        start_i = 1'b0;
        run_done(12, dn);
        chki("t5_new_done", dn, 1);
        chki("t5_sb_empty", exp_q.size(), 0);

        // 6: async reset mid-DRAIN
        step();
        fifo_flush();
        fifo_load('h600, 2);
        m_ready_i = 1'b0;
        start_i = 1'b1;
        len_i = 16'd2;
        step();
        start_i = 1'b0;
        repeat (4) step();
        #2;
        chk1("t6_pre_busy", busy_o, 1'b1);
        chk1("t6_pre_valid", m_valid_o, 1'b1);
        chkw("t6_pre_data", m_data_o, 'h600);
        rstn = 1'b0;
        #1;
        chk_zero("t6_async");
        step();
        rstn = 1'b1;
        step();
        fifo_flush();
        fifo_load('h500, 2);
        exp_push('h500, 2);
        m_ready_i = 1'b1;
        start_i = 1'b1;
        len_i = 16'd2;
        step();
        start_i = 1'b0;
        run_done(12, dn);
        chki("t6_done_after_reset", dn, 1);
        chki("t6_sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
